control_unit: RTL and testbench

Multi-cycle sequencer that sits directly upstream of `datapath`. It generates every register-enable, bus-drive, ALU-select and memory strobe for fetch, decode and execute, using the instruction register contents fed back from the datapath. It is a Moore-style FSM with one clock-cycle step per state. It stalls on a memory-ready handshake and halts on `halt` or an illegal opcode.

---
 rtl/cpu_pkg.sv | 104 ++++++++++
 rtl/control_unit_if.sv | 30 +++
 rtl/instr_decode.sv | 25 ++
 rtl/control_unit.sv | 181 ++++++++++++++++++
 tb/tb_control_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU select encoding, sequencer states and
// the control-word layout driven by the control unit.
package cpu_pkg;

  localparam int unsigned IR_W    = 32;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned OPC_LSB = 27;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'b00000;
  localparam opcode_t OP_SUB  = 5'b00001;
  localparam opcode_t OP_AND  = 5'b00010;
  localparam opcode_t OP_OR   = 5'b00011;
  localparam opcode_t OP_LD   = 5'b00100;
  localparam opcode_t OP_ST   = 5'b00101;
  localparam opcode_t OP_ADDI = 5'b01000;
  localparam opcode_t OP_MUL  = 5'b01110;
  localparam opcode_t OP_DIV  = 5'b01111;
  localparam opcode_t OP_MFHI = 5'b10000;
  localparam opcode_t OP_MFLO = 5'b10001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_MUL = 4'd4,
    ALU_DIV = 4'd5
  } alu_op_e;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_e;

  typedef struct packed {
    logic rtype;
    logic muldiv;
    logic addi;
    logic ld;
    logic st;
    logic mfhi;
    logic mflo;
    logic nop;
    logic halt;
    logic illegal;
  } iclass_t;

  typedef struct packed {
    logic    pco;
    logic    pci;
    logic    incpc;
    logic    iri;
    logic    mari;
    logic    mdri;
    logic    mdro;
    logic    read;
    logic    write;
    logic    yi;
    logic    zi;
    logic    zlowo;
    logic    zhigho;
    logic    hii;
    logic    loi;
    logic    hio;
    logic    loo;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    rin;
    logic    rout;
    logic    bapo;
    logic    cout;
    alu_op_e alu_op;
    logic    run;
  } ctrl_t;

  // ALU function for register-register arithmetic opcodes; everything else adds.
  function automatic alu_op_e alu_sel(input opcode_t opc);
    alu_op_e sel;
    case (opc)
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_MUL:  sel = ALU_MUL;
      OP_DIV:  sel = ALU_DIV;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR feedback and memory handshake in,
// every register/bus/memory strobe out.
interface control_unit_if;
  import cpu_pkg::*;

  logic [IR_W-1:0]  ir;
  logic             mem_ready;
  logic             pco, pci, incpc, iri;
  logic             mari, mdri, mdro, read, write;
  logic             yi, zi, zlowo, zhigho;
  logic             hii, loi, hio, loo;
  logic             gra, grb, grc, rin, rout, bapo, cout;
  logic [ALU_W-1:0] alu_op;
  logic             run;

  modport master (
    input  ir, mem_ready,
    output pco, pci, incpc, iri, mari, mdri, mdro, read, write,
           yi, zi, zlowo, zhigho, hii, loi, hio, loo,
           gra, grb, grc, rin, rout, bapo, cout, alu_op, run
  );

  modport slave (
    output ir, mem_ready,
    input  pco, pci, incpc, iri, mari, mdri, mdro, read, write,
           yi, zi, zlowo, zhigho, hii, loi, hio, loo,
           gra, grb, grc, rin, rout, bapo, cout, alu_op, run
  );

endinterface

// File: rtl/instr_decode.sv
// Opcode to instruction-class flags; exactly one flag is set for any opcode.
module instr_decode
  import cpu_pkg::*;
(
  input  opcode_t opcode,
  output iclass_t iclass
);

  always_comb begin
    iclass = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: iclass.rtype   = 1'b1;
      OP_MUL, OP_DIV:                iclass.muldiv  = 1'b1;
      OP_ADDI:                       iclass.addi    = 1'b1;
      OP_LD:                         iclass.ld      = 1'b1;
      OP_ST:                         iclass.st      = 1'b1;
      OP_MFHI:                       iclass.mfhi    = 1'b1;
      OP_MFLO:                       iclass.mflo    = 1'b1;
      OP_NOP:                        iclass.nop     = 1'b1;
      OP_HALT:                       iclass.halt    = 1'b1;
      default:                       iclass.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer: fetch T0-T2, opcode-dependent execute T3-T7,
// sticky HALT on halt/illegal opcode; only clear leaves HALT.
module control_unit
  import cpu_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master bus
);

  state_e  state;
  state_e  state_nxt;
  opcode_t opcode;
  iclass_t ic;
  ctrl_t   ctrl;
  logic    unused_ir;

  assign opcode    = bus.ir[IR_W-1:OPC_LSB];
  assign unused_ir = ^bus.ir[OPC_LSB-1:0];

  instr_decode u_decode (
    .opcode (opcode),
    .iclass (ic)
  );

  // State register: the only storage; clear forces RESET (all strobes low).
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= ST_RESET;
    else        state <= state_nxt;
  end

  // Next state and Moore control word; stalled states keep their strobes.
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      ST_RESET: state_nxt = ST_T0;
      ST_T0: begin
        ctrl.pco   = 1'b1;
        ctrl.mari  = 1'b1;
        ctrl.incpc = 1'b1;
        ctrl.zi    = 1'b1;
        state_nxt  = ST_T1;
      end
      ST_T1: begin
        ctrl.zlowo = 1'b1;
        ctrl.pci   = 1'b1;
        ctrl.read  = 1'b1;
        ctrl.mdri  = 1'b1;
        if (bus.mem_ready) state_nxt = ST_T2;
      end
      ST_T2: begin
        ctrl.mdro = 1'b1;
        ctrl.iri  = 1'b1;
        state_nxt = ST_T3;
      end
      ST_T3: begin
        if (ic.rtype || ic.muldiv || ic.addi) begin
          ctrl.grb  = 1'b1;
          ctrl.rout = 1'b1;
          ctrl.yi   = 1'b1;
          state_nxt = ST_T4;
        end else if (ic.ld || ic.st) begin
          ctrl.grb  = 1'b1;
          ctrl.bapo = 1'b1;
          ctrl.yi   = 1'b1;
          state_nxt = ST_T4;
        end else if (ic.mfhi) begin
          ctrl.hio  = 1'b1;
          ctrl.gra  = 1'b1;
          ctrl.rin  = 1'b1;
          state_nxt = ST_T0;
        end else if (ic.mflo) begin
          ctrl.loo  = 1'b1;
          ctrl.gra  = 1'b1;
          ctrl.rin  = 1'b1;
          state_nxt = ST_T0;
        end else if (ic.nop) begin
          state_nxt = ST_T0;
        end else begin
          state_nxt = ST_HALT;
        end
      end
      ST_T4: begin
        if (ic.rtype || ic.muldiv) begin
          ctrl.grc    = 1'b1;
          ctrl.rout   = 1'b1;
          ctrl.zi     = 1'b1;
          ctrl.alu_op = alu_sel(opcode);
          state_nxt   = ST_T5;
        end else if (ic.addi || ic.ld || ic.st) begin
          ctrl.cout   = 1'b1;
          ctrl.zi     = 1'b1;
          ctrl.alu_op = ALU_ADD;
          state_nxt   = ST_T5;
        end else begin
          state_nxt = ST_HALT;
        end
      end
      ST_T5: begin
        ctrl.zlowo = 1'b1;
        if (ic.rtype || ic.addi) begin
          ctrl.gra  = 1'b1;
          ctrl.rin  = 1'b1;
          state_nxt = ST_T0;
        end else if (ic.muldiv) begin
          ctrl.loi  = 1'b1;
          state_nxt = ST_T6;
        end else if (ic.ld || ic.st) begin
          ctrl.mari = 1'b1;
          state_nxt = ST_T6;
        end else begin
          ctrl.zlowo = 1'b0;
          state_nxt  = ST_HALT;
        end
      end
      ST_T6: begin
        if (ic.muldiv) begin
          ctrl.zhigho = 1'b1;
          ctrl.hii    = 1'b1;
          state_nxt   = ST_T0;
        end else if (ic.ld) begin
          ctrl.read = 1'b1;
          ctrl.mdri = 1'b1;
          if (bus.mem_ready) state_nxt = ST_T7;
        end else if (ic.st) begin
          ctrl.gra  = 1'b1;
          ctrl.rout = 1'b1;
          ctrl.mdri = 1'b1;
          state_nxt = ST_T7;
        end else begin
          state_nxt = ST_HALT;
        end
      end
      ST_T7: begin
        if (ic.ld) begin
          ctrl.mdro = 1'b1;
          ctrl.gra  = 1'b1;
          ctrl.rin  = 1'b1;
          state_nxt = ST_T0;
        end else if (ic.st) begin
          ctrl.write = 1'b1;
          if (bus.mem_ready) state_nxt = ST_T0;
        end else begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_HALT;
    endcase
    ctrl.run = (state != ST_RESET) && (state != ST_HALT);
  end

  assign bus.pco    = ctrl.pco;
  assign bus.pci    = ctrl.pci;
  assign bus.incpc  = ctrl.incpc;
  assign bus.iri    = ctrl.iri;
  assign bus.mari   = ctrl.mari;
  assign bus.mdri   = ctrl.mdri;
  assign bus.mdro   = ctrl.mdro;
  assign bus.read   = ctrl.read;
  assign bus.write  = ctrl.write;
  assign bus.yi     = ctrl.yi;
  assign bus.zi     = ctrl.zi;
  assign bus.zlowo  = ctrl.zlowo;
  assign bus.zhigho = ctrl.zhigho;
  assign bus.hii    = ctrl.hii;
  assign bus.loi    = ctrl.loi;
  assign bus.hio    = ctrl.hio;
  assign bus.loo    = ctrl.loo;
  assign bus.gra    = ctrl.gra;
  assign bus.grb    = ctrl.grb;
  assign bus.grc    = ctrl.grc;
  assign bus.rin    = ctrl.rin;
  assign bus.rout   = ctrl.rout;
  assign bus.bapo   = ctrl.bapo;
  assign bus.cout   = ctrl.cout;
  assign bus.alu_op = ALU_W'(ctrl.alu_op);
  assign bus.run    = ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe sequences built from
// the micro-step tables, directed corner cases and randomized instruction streams.
module tb_control_unit;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  control_unit_if bus ();

  control_unit dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  localparam logic [23:0] S_PCO    = 24'd1 << 0;
  localparam logic [23:0] S_PCI    = 24'd1 << 1;
  localparam logic [23:0] S_INCPC  = 24'd1 << 2;
  localparam logic [23:0] S_IRI    = 24'd1 << 3;
  localparam logic [23:0] S_MARI   = 24'd1 << 4;
  localparam logic [23:0] S_MDRI   = 24'd1 << 5;
  localparam logic [23:0] S_MDRO   = 24'd1 << 6;
  localparam logic [23:0] S_READ   = 24'd1 << 7;
  localparam logic [23:0] S_WRITE  = 24'd1 << 8;
  localparam logic [23:0] S_YI     = 24'd1 << 9;
  localparam logic [23:0] S_ZI     = 24'd1 << 10;
  localparam logic [23:0] S_ZLOWO  = 24'd1 << 11;
  localparam logic [23:0] S_ZHIGHO = 24'd1 << 12;
  localparam logic [23:0] S_HII    = 24'd1 << 13;
  localparam logic [23:0] S_LOI    = 24'd1 << 14;
  localparam logic [23:0] S_HIO    = 24'd1 << 15;
  localparam logic [23:0] S_LOO    = 24'd1 << 16;
  localparam logic [23:0] S_GRA    = 24'd1 << 17;
  localparam logic [23:0] S_GRB    = 24'd1 << 18;
  localparam logic [23:0] S_GRC    = 24'd1 << 19;
  localparam logic [23:0] S_RIN    = 24'd1 << 20;
  localparam logic [23:0] S_ROUT   = 24'd1 << 21;
  localparam logic [23:0] S_BAPO   = 24'd1 << 22;
  localparam logic [23:0] S_COUT   = 24'd1 << 23;

  localparam logic [28:0] W_T0 = {1'b1, 4'd0, S_PCO | S_MARI | S_INCPC | S_ZI};

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          cycles;
    logic [3:0]  alu;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [28:0] exp_q[$];
  int          kind_q[$];   // 0: no wait, 1: fetch wait, 2: data-memory wait
  bit          halts;
  logic [4:0]  legal[12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd14, 5'd15, 5'd8, 5'd4, 5'd5, 5'd16, 5'd17, 5'd26};
  vec_t        tbl[12];

  function automatic logic [28:0] sample();
    return {bus.run, bus.alu_op, bus.cout, bus.bapo, bus.rout, bus.rin, bus.grc, bus.grb,
            bus.gra, bus.loo, bus.hio, bus.loi, bus.hii, bus.zhigho, bus.zlowo, bus.zi,
            bus.yi, bus.write, bus.read, bus.mdro, bus.mdri, bus.mari, bus.iri, bus.incpc,
            bus.pci, bus.pco};
  endfunction

  task automatic check(input string nm, input logic [28:0] exp);
    logic [28:0] act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] s, input logic [3:0] a, input int k);
    exp_q.push_back({1'b1, a, s});
    kind_q.push_back(k);
  endtask

  // Expected per-step outputs of one instruction, straight from the micro-step table.
  task automatic build_steps(input logic [4:0] opc);
    exp_q.delete();
    kind_q.delete();
    halts = 1'b0;
    push(S_PCO | S_MARI | S_INCPC | S_ZI, 4'd0, 0);
    push(S_ZLOWO | S_PCI | S_READ | S_MDRI, 4'd0, 1);
    push(S_MDRO | S_IRI, 4'd0, 0);
    case (opc)
      5'd0, 5'd1, 5'd2, 5'd3: begin
        push(S_GRB | S_ROUT | S_YI, 4'd0, 0);
        push(S_GRC | S_ROUT | S_ZI, 4'(opc), 0);
        push(S_ZLOWO | S_GRA | S_RIN, 4'd0, 0);
      end
      5'd14, 5'd15: begin
        push(S_GRB | S_ROUT | S_YI, 4'd0, 0);
        push(S_GRC | S_ROUT | S_ZI, (opc == 5'd14) ? 4'd4 : 4'd5, 0);
        push(S_ZLOWO | S_LOI, 4'd0, 0);
        push(S_ZHIGHO | S_HII, 4'd0, 0);
      end
      5'd8: begin
        push(S_GRB | S_ROUT | S_YI, 4'd0, 0);
        push(S_COUT | S_ZI, 4'd0, 0);
        push(S_ZLOWO | S_GRA | S_RIN, 4'd0, 0);
      end
      5'd4, 5'd5: begin
        push(S_GRB | S_BAPO | S_YI, 4'd0, 0);
        push(S_COUT | S_ZI, 4'd0, 0);
        push(S_ZLOWO | S_MARI, 4'd0, 0);
        if (opc == 5'd4) begin
          push(S_READ | S_MDRI, 4'd0, 2);
          push(S_MDRO | S_GRA | S_RIN, 4'd0, 0);
        end else begin
          push(S_GRA | S_ROUT | S_MDRI, 4'd0, 0);
          push(S_WRITE, 4'd0, 2);
        end
      end
      5'd16: push(S_HIO | S_GRA | S_RIN, 4'd0, 0);
      5'd17: push(S_LOO | S_GRA | S_RIN, 4'd0, 0);
      5'd26: push(24'd0, 4'd0, 0);
      default: begin
        push(24'd0, 4'd0, 0);
        halts = 1'b1;
      end
    endcase
  endtask

  // Runs one instruction from its T0 cycle; the model advances only when memory is ready.
  task automatic run_instr(input logic [31:0] irv, input bit rnd, input int late_wait,
                           input string tag, output int cycles, output logic [3:0] alu_t4);
    int          idx;
    int          waited;
    bit          mr;
    logic [28:0] s;
    build_steps(irv[31:27]);
    bus.ir = irv;
    idx    = 0;
    waited = 0;
    cycles = 0;
    alu_t4 = 4'd0;
    while (idx < exp_q.size()) begin
      check(tag, exp_q[idx]);
      if (cycles == 4) begin
        s      = sample();
        alu_t4 = s[27:24];
      end
      cycles++;
      if (rnd)                  mr = ($urandom_range(0, 2) != 0);
      else if (kind_q[idx] == 2) mr = (waited >= late_wait);
      else                      mr = 1'b1;
      bus.mem_ready = mr;
      if (kind_q[idx] == 0 || mr) begin
        idx++;
        waited = 0;
      end else begin
        waited++;
      end
      if (cycles > 400) begin
        checks++;
        errors++;
        $display("FAIL %s: instruction did not complete within 400 cycles", tag);
        break;
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_halted(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check(tag, 29'd0);
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.ir        = $urandom;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic recover(input string tag);
    clear = 1'b0;
    #1;
    check({tag, "_clr"}, 29'd0);
    @(posedge clock);
    #1;
    check({tag, "_clr_hold"}, 29'd0);
    clear         = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clock);
    #1;
    check({tag, "_restart"}, W_T0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [3:0]  alu;
    logic [4:0]  op;
    logic [31:0] irv;

    tbl[0]  = '{"ADD",  32'h0091_8000, 6, 4'd0};
    tbl[1]  = '{"SUB",  32'h0800_0000, 6, 4'd1};
    tbl[2]  = '{"AND",  32'h1000_0000, 6, 4'd2};
    tbl[3]  = '{"OR",   32'h1800_0000, 6, 4'd3};
    tbl[4]  = '{"MUL",  32'h7000_0000, 7, 4'd4};
    tbl[5]  = '{"DIV",  32'h7800_0000, 7, 4'd5};
    tbl[6]  = '{"ADDI", 32'h4000_0000, 6, 4'd0};
    tbl[7]  = '{"LD",   32'h2000_0000, 8, 4'd0};
    tbl[8]  = '{"ST",   32'h2800_0000, 8, 4'd0};
    tbl[9]  = '{"MFHI", 32'h8000_0000, 4, 4'd0};
    tbl[10] = '{"MFLO", 32'h8800_0000, 4, 4'd0};
    tbl[11] = '{"NOP",  32'hD000_0000, 4, 4'd0};

    // Reset held for three cycles, then released.
    clear         = 1'b0;
    bus.ir        = 32'd0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("reset", 29'd0);
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
    check("release_t0", W_T0);

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].ir, 1'b0, 0, tbl[i].name, cyc, alu);
      check_int({tbl[i].name, "_latency"}, cyc, tbl[i].cycles);
      if (tbl[i].cycles >= 6) check_int({tbl[i].name, "_alu_t4"}, int'(alu), int'(tbl[i].alu));
    end

    // LD with three data-memory wait cycles.
    run_instr(32'h2000_0000, 1'b0, 3, "LD_stall", cyc, alu);
    check_int("LD_stall_latency", cyc, 11);

    // Illegal opcode halts after T3 and stays halted.
    run_instr(32'hF800_0000, 1'b0, 0, "ILL", cyc, alu);
    check_int("ILL_latency", cyc, 4);
    check_halted(20, "ILL_halted");
    recover("ILL");

    // clear during an ST write stall.
    build_steps(5'd5);
    bus.ir        = 32'h2800_0000;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("ST_pre", exp_q[i]);
      @(posedge clock);
      #1;
    end
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ST_stall", exp_q[7]);
      @(posedge clock);
      #1;
    end
    #1;
    recover("ST");

    // Randomized instruction stream with random memory readiness.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 31));
      else                           op = legal[$urandom_range(0, 11)];
      irv = {op, 27'($urandom)};
      run_instr(irv, 1'b1, 0, "rnd", cyc, alu);
      if (halts) begin
        check_halted(5, "rnd_halted");
        recover("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
